// File: rtl/dsm_cifb.sv
// N-th order CIFB delta-sigma modulator: saturating integrators, overload recovery, underrun pulse.
// Optional quantizer dither from a 16-bit LFSR is built when DSM_DITHER_EN is defined.
module dsm_cifb #(
  parameter int DATA_W    = 16,
  parameter int ORDER     = 2,
  parameter int OSR       = 8,
  parameter int STAGE_SHR = 1,
  parameter int OVL_LIMIT = 16,
  parameter int DITH_W    = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              en,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              pwm,
  output logic              ovl,
  output logic              underrun
);

  localparam int IW  = DATA_W + 4;
  localparam int SW  = IW + 2;
  localparam int CW  = $clog2(OSR);
  localparam int SCW = $clog2(OVL_LIMIT + 1);

  localparam logic signed [IW-1:0] FB_POS = {{(IW-DATA_W+1){1'b0}}, 1'b1, {(DATA_W-2){1'b0}}};
  localparam logic signed [IW-1:0] FB_NEG = -FB_POS;
  localparam logic signed [SW-1:0] SW_MAX = {3'b000, {(IW-1){1'b1}}};
  localparam logic signed [SW-1:0] SW_MIN = {3'b111, {(IW-1){1'b0}}};

  if (ORDER < 1 || ORDER > 4) begin : g_bad_order
    $error("dsm_cifb: ORDER must be in 1..4");
  end
  if (OSR < 2 || OVL_LIMIT < 1 || DITH_W < 1 || DITH_W > 16) begin : g_bad_param
    $error("dsm_cifb: OSR >= 2, OVL_LIMIT >= 1, DITH_W in 1..16 required");
  end

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RUN     = 2'd1,
    S_RECOVER = 2'd2
  } state_t;

  state_t                    state_q, state_d;
  logic signed [IW-1:0]      int_q [ORDER];
  logic signed [IW-1:0]      int_d [ORDER];
  logic signed [DATA_W-1:0]  x_q, x_d;
  logic [CW-1:0]             osr_q, osr_d;
  logic [SCW-1:0]            sat_cnt_q, sat_cnt_d;
  logic                      pwm_q, pwm_d;
  logic                      ovl_q, ovl_d;
  logic                      underrun_q, underrun_d;

  logic signed [IW-1:0]      fb_s;
  logic signed [SW-1:0]      sum_s [ORDER];
  logic signed [IW-1:0]      upd_s [ORDER];
  logic                      sat_s;
  logic                      slot_s;
  logic                      q_msb_s;

  function automatic logic signed [IW-1:0] clamp_iw(input logic signed [SW-1:0] v);
    if (v > SW_MAX) begin
      return SW_MAX[IW-1:0];
    end else if (v < SW_MIN) begin
      return SW_MIN[IW-1:0];
    end else begin
      return v[IW-1:0];
    end
  endfunction

  // Integrator chain: every stage is fed from the previous cycle's values.
  always_comb begin
    fb_s     = pwm_q ? FB_POS : FB_NEG;
    sum_s[0] = SW'(int_q[0]) + SW'(x_q) - SW'(fb_s);
    for (int k = 1; k < ORDER; k++) begin
      sum_s[k] = SW'(int_q[k]) + SW'(int_q[k-1] >>> STAGE_SHR) - SW'(fb_s);
    end
    sat_s = 1'b0;
    for (int k = 0; k < ORDER; k++) begin
      upd_s[k] = clamp_iw(sum_s[k]);
      sat_s    = sat_s | (sum_s[k] > SW_MAX) | (sum_s[k] < SW_MIN);
    end
  end

`ifdef DSM_DITHER_EN
  logic [15:0]          lfsr_q, lfsr_d;
  logic signed [SW-1:0] q_s;

  // Dither only biases the quantizer decision; it never enters the integrators.
  always_comb begin
    if (en && state_q == S_RUN) begin
      lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end else begin
      lfsr_d = lfsr_q;
    end
    q_s = SW'(upd_s[ORDER-1]) + SW'($signed(lfsr_q[DITH_W-1:0]));
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      lfsr_q <= 16'hACE1;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign q_msb_s = q_s[SW-1];
`else
  assign q_msb_s = upd_s[ORDER-1][IW-1];
`endif

  // Control: handshake, slot counter, overload tracking and next state.
  always_comb begin
    state_d    = state_q;
    int_d      = int_q;
    x_d        = x_q;
    osr_d      = osr_q;
    sat_cnt_d  = sat_cnt_q;
    pwm_d      = pwm_q;
    ovl_d      = 1'b0;
    underrun_d = 1'b0;
    slot_s     = (osr_q == CW'(OSR - 1));
    in_ready   = en && (state_q == S_IDLE || slot_s);
    if (en) begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            x_d     = in_data;
            state_d = S_RUN;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_RUN: begin
          int_d = upd_s;
          pwm_d = ~q_msb_s;
          if (sat_s) begin
            sat_cnt_d = sat_cnt_q + SCW'(1);
            if (sat_cnt_q == SCW'(OVL_LIMIT - 1)) begin
              state_d = S_RECOVER;
              ovl_d   = 1'b1;
            end else begin
              state_d = S_RUN;
            end
          end else begin
            sat_cnt_d = '0;
          end
        end
        S_RECOVER: begin
          int_d     = '{default: '0};
          pwm_d     = 1'b0;
          sat_cnt_d = '0;
          state_d   = S_RUN;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
      // Slot bookkeeping continues through RECOVER so sample timing never slips.
      if (state_q != S_IDLE) begin
        osr_d = slot_s ? '0 : osr_q + CW'(1);
        if (slot_s && in_valid) begin
          x_d = in_data;
        end else if (slot_s) begin
          underrun_d = 1'b1;
        end else begin
          underrun_d = 1'b0;
        end
      end else begin
        osr_d = osr_q;
      end
    end else begin
      state_d = state_q;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_IDLE;
      int_q      <= '{default: '0};
      x_q        <= '0;
      osr_q      <= '0;
      sat_cnt_q  <= '0;
      pwm_q      <= 1'b0;
      ovl_q      <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      int_q      <= int_d;
      x_q        <= x_d;
      osr_q      <= osr_d;
      sat_cnt_q  <= sat_cnt_d;
      pwm_q      <= pwm_d;
      ovl_q      <= ovl_d;
      underrun_q <= underrun_d;
    end
  end

  assign pwm      = pwm_q;
  assign ovl      = ovl_q;
  assign underrun = underrun_q;

endmodule

// File: tb/tb_dsm_cifb.sv
// Bench for dsm_cifb: an ORDER=2 and an ORDER=1 instance share stimulus and are
// checked every cycle against an arithmetic reference model of the modulator.
module tb_dsm_cifb;

  localparam int     OSR       = 8;
  localparam int     OVL_LIMIT = 16;
  localparam longint FB        = 16384;
  localparam longint IMAX      = 524287;
  localparam longint IMIN      = -524288;

  logic        clock = 1'b0;
  logic        reset;
  logic        en;
  logic        in_valid;
  logic [15:0] in_data;
  logic        rdy2, pwm2, ovl2, und2;
  logic        rdy1, pwm1, ovl1, und1;

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model state, index 0 = ORDER 2, index 1 = ORDER 1.
  int     m_st  [2];
  longint m_i   [2][4];
  longint m_x   [2];
  int     m_osr [2];
  int     m_sat [2];
  bit     m_pwm [2];
  bit     m_ovl [2];
  bit     m_und [2];

  dsm_cifb #(.DATA_W(16), .ORDER(2), .OSR(OSR), .STAGE_SHR(1), .OVL_LIMIT(OVL_LIMIT), .DITH_W(4)) u_dut2 (
    .clock(clock), .reset(reset), .en(en), .in_data(in_data), .in_valid(in_valid),
    .in_ready(rdy2), .pwm(pwm2), .ovl(ovl2), .underrun(und2));

  dsm_cifb #(.DATA_W(16), .ORDER(1), .OSR(OSR), .STAGE_SHR(1), .OVL_LIMIT(OVL_LIMIT), .DITH_W(4)) u_dut1 (
    .clock(clock), .reset(reset), .en(en), .in_data(in_data), .in_valid(in_valid),
    .in_ready(rdy1), .pwm(pwm1), .ovl(ovl1), .underrun(und1));

  initial forever #5 clock = ~clock;

  task automatic chk(input string tag, input logic obs, input logic expv);
    n_chk++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: observed %0b expected %0b", tag, obs, expv);
  endtask

  task automatic chk_rng(input string tag, input int obs, input int lo, input int hi);
    n_chk++;
    assert ((obs >= lo && obs <= hi) === 1'b1) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d..%0d", tag, obs, lo, hi);
  endtask

  function automatic bit m_ready(input int j, input bit e);
    return e && (m_st[j] == 0 || m_osr[j] == OSR - 1);
  endfunction

  task automatic m_step(input int j, input bit r, input bit v, input logic [15:0] d, input bit e);
    int     ord;
    longint nv [4];
    longint fbv;
    longint raw;
    bit     sat;
    bit     slot;
    ord = (j == 0) ? 2 : 1;
    m_ovl[j] = 1'b0;
    m_und[j] = 1'b0;
    if (r) begin
      m_st[j] = 0; m_pwm[j] = 1'b0; m_osr[j] = 0; m_sat[j] = 0; m_x[j] = 0;
      for (int k = 0; k < 4; k++) m_i[j][k] = 0;
    end else if (e) begin
      if (m_st[j] == 0) begin
        if (v) begin
          m_x[j]  = longint'($signed(d));
          m_st[j] = 1;
        end
      end else begin
        slot = (m_osr[j] == OSR - 1);
        if (m_st[j] == 2) begin
          for (int k = 0; k < 4; k++) m_i[j][k] = 0;
          m_pwm[j] = 1'b0;
          m_sat[j] = 0;
          m_st[j]  = 1;
        end else begin
          fbv = m_pwm[j] ? FB : -FB;
          sat = 1'b0;
          for (int k = 0; k < ord; k++) begin
            if (k == 0) raw = m_i[j][0] + m_x[j] - fbv;
            else        raw = m_i[j][k] + (m_i[j][k-1] >>> 1) - fbv;
            if (raw > IMAX) begin
              raw = IMAX; sat = 1'b1;
            end else if (raw < IMIN) begin
              raw = IMIN; sat = 1'b1;
            end
            nv[k] = raw;
          end
          for (int k = 0; k < ord; k++) m_i[j][k] = nv[k];
          m_pwm[j] = (nv[ord-1] >= 0);
          if (sat) begin
            m_sat[j]++;
            if (m_sat[j] >= OVL_LIMIT) begin
              m_st[j]  = 2;
              m_ovl[j] = 1'b1;
            end
          end else begin
            m_sat[j] = 0;
          end
        end
        m_osr[j] = (m_osr[j] + 1) % OSR;
        if (slot) begin
          if (v) m_x[j] = longint'($signed(d));
          else   m_und[j] = 1'b1;
        end
      end
    end
  endtask

  task automatic cyc(input bit r, input bit v, input logic [15:0] d, input bit e);
    reset = r; in_valid = v; in_data = d; en = e;
    #1;
    chk("in_ready_o2", rdy2, m_ready(0, e));
    chk("in_ready_o1", rdy1, m_ready(1, e));
    @(posedge clock);
    m_step(0, r, v, d, e);
    m_step(1, r, v, d, e);
    @(negedge clock);
    chk("pwm_o2", pwm2, m_pwm[0]);
    chk("pwm_o1", pwm1, m_pwm[1]);
    chk("ovl_o2", ovl2, m_ovl[0]);
    chk("ovl_o1", ovl1, m_ovl[1]);
    chk("underrun_o2", und2, m_und[0]);
    chk("underrun_o1", und1, m_und[1]);
  endtask

  function automatic logic [15:0] rnd_sample();
    logic [15:0] s;
    s = 16'($urandom_range(0, 16383)) - 16'd8192;
    return s;
  endfunction

  initial begin
    logic [5:0] pat;
    int         ones;
    int         cnt;
    logic       held;
    logic       prev_ovl;

    reset = 1'b1; in_valid = 1'b1; in_data = 16'h1234; en = 1'b1;
    @(posedge clock);
    m_step(0, 1'b1, 1'b1, 16'h1234, 1'b1);
    m_step(1, 1'b1, 1'b1, 16'h1234, 1'b1);
    @(negedge clock);

    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 16'h1234, 1'b1);
    chk("reset_pwm", pwm2, 1'b0);
    chk("reset_ovl", ovl2, 1'b0);
    chk("reset_underrun", und2, 1'b0);
    chk("reset_in_ready", rdy2, 1'b1);

    // Zero input on ORDER 1 gives the 1,1,0,1,0,1 pattern then a 50% stream.
    pat = 6'b110101;
    cyc(1'b0, 1'b1, 16'h0000, 1'b1);
    chk("idle_accept_pwm", pwm1, 1'b0);
    for (int i = 0; i < 6; i++) begin
      cyc(1'b0, 1'b1, 16'h0000, 1'b1);
      chk("ord1_pattern", pwm1, pat[5-i]);
    end
    ones = 0;
    for (int i = 0; i < 64; i++) begin
      cyc(1'b0, 1'b1, 16'h0000, 1'b1);
      ones += int'(pwm1);
    end
    chk_rng("ord1_ones_64", ones, 31, 33);

    // Half-FB input, with one whole slot of dropped samples carrying junk data.
    for (int i = 0; i < 64; i++) cyc(1'b0, 1'b1, 16'h2000, 1'b1);
    cnt = 0;
    for (int i = 0; i < OSR; i++) begin
      cyc(1'b0, 1'b0, 16'h7FFF, 1'b1);
      cnt += int'(und2);
    end
    chk_rng("underrun_once", cnt, 1, 1);
    ones = 0; cnt = 0;
    for (int i = 0; i < 256; i++) begin
      cyc(1'b0, 1'b1, 16'h2000, 1'b1);
      ones += int'(pwm2);
      cnt  += int'(ovl2);
    end
    chk_rng("ord2_density_75", ones, 188, 196);
    chk_rng("no_ovl_half_fb", cnt, 0, 0);

    // Random samples with random sample drops.
    for (int i = 0; i < 150; i++) cyc(1'b0, ($urandom_range(0, 7) != 0), rnd_sample(), 1'b1);

    // Enable gap: everything frozen, then continues as if uninterrupted.
    held = pwm2;
    for (int i = 0; i < 20; i++) begin
      cyc(1'b0, 1'b1, rnd_sample(), 1'b0);
      chk("en_gap_pwm_frozen", pwm2, held);
      chk("en_gap_in_ready", rdy2, 1'b0);
    end
    for (int i = 0; i < 60; i++) cyc(1'b0, ($urandom_range(0, 7) != 0), rnd_sample(), 1'b1);

    // Full-scale input forces repeated overload recovery.
    cnt = 0; prev_ovl = 1'b0;
    for (int i = 0; i < 300; i++) begin
      cyc(1'b0, 1'b1, 16'h7FFF, 1'b1);
      if (prev_ovl) chk("pwm_zero_after_ovl", pwm2, 1'b0);
      prev_ovl = ovl2;
      cnt += int'(ovl2);
    end
    chk_rng("ovl_repeats", cnt, 2, 300);

    // Reset in the middle of overload activity.
    cyc(1'b1, 1'b1, 16'h7FFF, 1'b1);
    cyc(1'b1, 1'b1, 16'h7FFF, 1'b1);
    chk("midrun_reset_pwm", pwm2, 1'b0);
    chk("midrun_reset_ovl", ovl2, 1'b0);
    chk("midrun_reset_ready", rdy2, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/dsm_cifb.md
# dsm_cifb

Parametrised N-th order cascade-of-integrators-feedback (CIFB) delta-sigma modulator with a 1-bit output, the next-generation replacement for the fixed 4th-order DSM top. It accepts signed PCM samples through a valid/ready handshake, one every OSR clocks, and produces a registered 1-bit `pwm` stream at the clock rate. It adds saturating integrators, overload detection with automatic integrator recovery, input-underrun reporting, and a run enable.

## Interface
- `DATA_W`, 16: signed input sample width (two's complement).
- `ORDER`, 2: number of integrators, 1..4.
- `OSR`, 8: clocks per input sample, ≥2.
- `STAGE_SHR`, 1: arithmetic right shift applied between integrator k-1 and k (k≥1).
- `OVL_LIMIT`, 16: consecutive saturating cycles that trigger recovery, ≥1.
- `DITH_W`, 4: dither magnitude bits (used only with `DSM_DITHER_EN`).

Ports:
- `clock` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `en` in 1: run enable; low freezes all state.
- `in_data` in DATA_W: signed sample.
- `in_valid` in 1: sample present.
- `in_ready` out 1: block accepts `in_data` this cycle.
- `pwm` out 1: modulator bit (1 = +FB, 0 = −FB).
- `ovl` out 1: one-cycle pulse when overload recovery fires.
- `underrun` out 1: one-cycle pulse when a sample slot passes without a sample.

## Operation
- Internal width IW = DATA_W+4 (4 guard bits). FB = 2^(DATA_W-2) (half full scale). fb = `pwm` ? +FB : −FB, sign-extended to IW.
- Integrators i[0..ORDER-1], IW bits signed. Next values are computed in IW+2 bits, then clamped to [−2^(IW-1), 2^(IW-1)−1]:
  - i[0] += x − fb
  - i[k] += (i[k-1] >>> STAGE_SHR) − fb
  - Clamp active on any stage → `sat` for this cycle.
- Quantizer: q = value of i[ORDER-1] after update (plus dither if enabled); `pwm` <= ~q[MSB], so q ≥ 0 gives 1.
- x is held in a register x_reg, sign-extended to IW.
- FSM:
  - IDLE (after reset): `in_ready`=1; integrators and `pwm` stay 0; osr_cnt=0. When `in_valid` is accepted, x_reg <= `in_data` and the FSM goes to RUN.
  - RUN: integrators update every enabled cycle. osr_cnt counts 0..OSR−1 and wraps. `in_ready`=1 only when osr_cnt==OSR−1 and `en`=1.
    - Accept at that cycle: x_reg updates.
    - No `in_valid` at that cycle: x_reg holds, `underrun` pulses next cycle.
    - sat_cnt increments on each `sat` cycle and clears on any non-sat cycle. Reaching OVL_LIMIT moves the FSM to RECOVER.
  - RECOVER (1 cycle): all integrators <= 0, sat_cnt <= 0, `pwm` <= 0, `ovl`=1, osr_cnt keeps counting. Returns to RUN.
- `en`=0: no state changes (integrators, `pwm`, counters, FSM, x_reg); `in_ready`=0; no pulses.
- `reset` overrides everything, including mid-RECOVER and mid-handshake.

## Timing
- Reset values: `pwm`=0, `in_ready`=1 (IDLE, combinational from state), `ovl`=0, `underrun`=0, integrators 0, osr_cnt 0, sat_cnt 0.
- Sample accepted on edge t → x_reg valid after t → first integration with it at edge t+1 → `pwm` reflects it after t+1 (latency 1 clock, input to first-stage contribution).
- `pwm` changes only on rising edges; fb in cycle n uses `pwm` from edge n−1.
- `ovl` and `underrun` are registered, each exactly one cycle wide.
- Simultaneous RECOVER and sample accept: both happen; x_reg updates and integrators clear.

## Configuration
- `DSM_DITHER_EN` defined:
  - 16-bit Fibonacci LFSR, taps 16,14,13,11, seed 16'hACE1 on reset.
  - Advances on each RUN cycle with `en`=1.
  - lfsr[DITH_W-1:0], treated as signed and sign-extended, is added to i[ORDER-1] for the quantizer decision only; it is never stored.
- Undefined: no LFSR logic; q = i[ORDER-1]. Output is bit-exact deterministic.

## Test plan
- Reset: hold `reset` 3 cycles with `in_valid`=1 → `pwm`=0, `ovl`=0, `underrun`=0, `in_ready`=1; no accept during reset.
- ORDER=1, DATA_W=16, OSR=8, `in_data`=0 every slot → `pwm` = 1,1,0,1,0,1,0…; ones count = 32±1 over 64 cycles.
- ORDER=2, `in_data`=16'h2000 (FB/2) continuous → ones density 75% ±1 bit over 256 cycles; no `ovl`.
- Drop `in_valid` for one slot in RUN → `underrun` pulses once, one cycle after the OSR−1 cycle; x_reg keeps its previous value (check that `pwm` density is unchanged).
- ORDER=2, OVL_LIMIT=16, `in_data`=16'h7FFF → `ovl` pulses; the cycle after, all integrators are 0 and `pwm`=0; the cycle repeats while overload persists.
- `en`=0 for 20 cycles mid-run → `pwm`, x_reg and osr_cnt are constant and `in_ready`=0; after `en` returns to 1, the `pwm` sequence continues identically to a run without the gap.
